sobol_int_to_fp_pipe: RTL

//   Pipelined, multi-lane converter from unsigned Sobol integers to the team's sign-less custom float
//   {exp, mantissa}. Parametrised successor of the combinational 32->16 converter: generic widths, N lanes,

---
 rtl/sobol_fp_pkg.sv | 38 +++
 rtl/sobol_int_to_fp_pipe_lod.sv | 20 ++
 rtl/sobol_int_to_fp_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sobol_fp_pkg.sv
// Shared helpers for the Sobol integer-to-float converter: width derivation
// and {exp, mantissa} field pack/unpack (fields up to 32 bits total).
package sobol_fp_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Exponent spans 0..IN_W-MAN_W.
    function automatic int unsigned exp_width(input int unsigned in_w, input int unsigned man_w);
        return clog2(in_w - man_w + 1);
    endfunction

    function automatic int unsigned out_width(input int unsigned in_w, input int unsigned man_w);
        return exp_width(in_w, man_w) + man_w;
    endfunction

    function automatic logic [31:0] fp_pack(input int unsigned man_w, input logic [31:0] e,
                                            input logic [31:0] m);
        logic [31:0] mask;
        mask = (32'd1 << man_w) - 32'd1;
        return (e << man_w) | (m & mask);
    endfunction

    function automatic logic [31:0] fp_exp(input int unsigned man_w, input logic [31:0] w);
        return w >> man_w;
    endfunction

    function automatic logic [31:0] fp_man(input int unsigned man_w, input logic [31:0] w);
        return w & ((32'd1 << man_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sobol_int_to_fp_pipe_lod.sv
// Leading-one detect: exponent = position of the top set bit minus (MAN_W-1),
// clamped to 0 when no bit at or above MAN_W is set.
module leading_one_detect import sobol_fp_pkg::*; #(
    parameter  int unsigned IN_W  = 32,
    parameter  int unsigned MAN_W = 12,
    localparam int unsigned EXP_W = exp_width(IN_W, MAN_W)
) (
    input  logic [IN_W-1:0]  value,
    output logic [EXP_W-1:0] exp
);

    // Priority encoder: highest qualifying bit wins (later iterations override).
    always_comb begin
        exp = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (value[i] && (i >= MAN_W)) exp = EXP_W'(i - (MAN_W - 1));
        end
    end

endmodule

// File: rtl/sobol_int_to_fp_pipe.sv
// Two-stage, N-lane unsigned integer -> {exp, man} converter with a shared
// valid/ready handshake. Define ROUND_NEAREST_EN for round-half-up with
// per-lane saturation flag; otherwise mantissa is truncated and out_sat is 0.
module sobol_int_to_fp_pipe import sobol_fp_pkg::*; #(
    parameter  int unsigned IN_W  = 32,
    parameter  int unsigned MAN_W = 12,
    parameter  int unsigned N_CH  = 1,
    localparam int unsigned EXP_W = exp_width(IN_W, MAN_W),
    localparam int unsigned OUT_W = EXP_W + MAN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*IN_W-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*OUT_W-1:0]   out_data,
    output logic [N_CH-1:0]         out_sat
);

    localparam logic [EXP_W-1:0] MAX_EXP = EXP_W'(IN_W - MAN_W);

    logic                 s1_valid;
    logic [IN_W-1:0]      s1_data [N_CH];
    logic [EXP_W-1:0]     s1_exp  [N_CH];
    logic [EXP_W-1:0]     lod_exp [N_CH];
    logic [OUT_W-1:0]     nxt_word [N_CH];
    logic [N_CH-1:0]      nxt_sat;
    logic [N_CH*OUT_W-1:0] nxt_flat;
    logic                 out_adv;

    // Output slot can take a word when empty or being drained this cycle.
    assign out_adv  = !out_valid || out_ready;
    assign in_ready = !s1_valid || out_adv;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        logic [MAN_W-1:0] man_f;
        logic [EXP_W-1:0] exp_f;
        logic             sat_f;
`ifdef ROUND_NEAREST_EN
        logic [MAN_W:0]   sum;
        logic             guard;
`endif

        leading_one_detect #(.IN_W(IN_W), .MAN_W(MAN_W)) u_lod (
            .value (in_data[k*IN_W +: IN_W]),
            .exp   (lod_exp[k])
        );

        // Stage-2 mantissa extraction (and rounding when enabled).
        always_comb begin
            man_f = MAN_W'(s1_data[k] >> s1_exp[k]);
            exp_f = s1_exp[k];
            sat_f = 1'b0;
`ifdef ROUND_NEAREST_EN
            guard = (s1_exp[k] != '0) &&
                    (((s1_data[k] >> (s1_exp[k] - EXP_W'(1))) & IN_W'(1)) != '0);
            sum   = {1'b0, man_f} + (MAN_W+1)'(guard);
            if (sum[MAN_W]) begin
                // Carry out of the mantissa renormalises, or saturates at the top exponent.
                if (s1_exp[k] == MAX_EXP) begin
                    man_f = '1;
                    sat_f = 1'b1;
                end else begin
                    man_f = MAN_W'(1) << (MAN_W - 1);
                    exp_f = s1_exp[k] + EXP_W'(1);
                end
            end else begin
                man_f = sum[MAN_W-1:0];
            end
`endif
        end

        assign nxt_word[k] = OUT_W'(fp_pack(MAN_W, 32'(exp_f), 32'(man_f)));
        assign nxt_sat[k]  = sat_f;
    end

    // Flatten lane words into the output bus layout.
    always_comb begin
        nxt_flat = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            nxt_flat[k*OUT_W +: OUT_W] = nxt_word[k];
        end
    end

    // Stage 1: capture raw lanes and their exponents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                s1_data[k] <= '0;
                s1_exp[k]  <= '0;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    s1_data[k] <= in_data[k*IN_W +: IN_W];
                    s1_exp[k]  <= lod_exp[k];
                end
            end
        end
    end

    // Stage 2: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= nxt_flat;
                out_sat  <= nxt_sat;
            end
        end
    end

endmodule
